// File: rtl/numpad_encoder_pkg.sv
// Shared definitions for the numeric keypad encoder: key count, FSM state
// encoding and small helpers for one-hot key vectors.
package numpad_encoder_pkg;

  localparam int NUM_KEYS = 10;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  function automatic logic [3:0] count_keys(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] total;
    total = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      total = total + {3'd0, keys[i]};
    end
    return total;
  endfunction

  function automatic logic [3:0] key_index(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/numpad_sync.sv
// Two-flop synchronizer bringing the raw key lines into the clk domain.
module numpad_sync #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1_reg;
  logic [WIDTH-1:0] stage2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_reg <= '0;
      stage2_reg <= '0;
    end else begin
      stage1_reg <= d;
      stage2_reg <= stage1_reg;
    end
  end

  assign q = stage2_reg;

endmodule

// File: rtl/numpad_encoder.sv
// Debounced 10-key numeric pad encoder: accepts a single stable key, reports
// its BCD digit with a one-cycle strobe and holds a debounced pressed level.
module numpad_encoder
  import numpad_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keypad,
  output logic                numpad_pressed,
  output logic [3:0]          bcd,
  output logic                key_valid,
  output logic                multi_key
);

  localparam logic [7:0] LAST_COUNT = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] MAX_COUNT  = 8'hFF;

  logic [NUM_KEYS-1:0] sk;
  logic [NUM_KEYS-1:0] cand_mask;
  logic [3:0]          sk_ones;
  logic                sk_onehot;

  state_t     state_reg, state_next;
  logic [7:0] count_reg, count_next;
  logic [3:0] cand_reg, cand_next;
  logic       pressed_reg, pressed_next;
  logic [3:0] bcd_reg, bcd_next;
  logic       valid_reg, valid_next;
  logic       multi_reg, multi_next;

  numpad_sync #(
    .WIDTH(NUM_KEYS)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (keypad),
    .q    (sk)
  );

  assign sk_ones   = count_keys(sk);
  assign sk_onehot = (sk_ones == 4'd1);
  assign cand_mask = {{(NUM_KEYS-1){1'b0}}, 1'b1} << cand_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      cand_reg    <= 4'd0;
      pressed_reg <= 1'b0;
      bcd_reg     <= 4'd0;
      valid_reg   <= 1'b0;
      multi_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      cand_reg    <= cand_next;
      pressed_reg <= pressed_next;
      bcd_reg     <= bcd_next;
      valid_reg   <= valid_next;
      multi_reg   <= multi_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    cand_next  = cand_reg;
    unique case (state_reg)
      IDLE: begin
        count_next = 8'd0;
        if (sk_onehot) begin
          cand_next  = key_index(sk);
          count_next = 8'd1;
          state_next = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (sk == cand_mask) begin
          if (count_reg == LAST_COUNT) begin
            state_next = HELD;
          end else if (count_reg != MAX_COUNT) begin
            count_next = count_reg + 8'd1;
          end
        end else begin
          count_next = 8'd0;
          state_next = IDLE;
        end
      end
      HELD: begin
        if (sk != cand_mask) begin
          count_next = (sk == '0) ? 8'd1 : 8'd0;
          state_next = DEB_RELEASE;
        end
      end
      DEB_RELEASE: begin
        // Any foreign key restarts the release debounce; the held key resumes HELD.
        if (sk == '0) begin
          if (count_reg == LAST_COUNT) begin
            count_next = 8'd0;
            state_next = IDLE;
          end else if (count_reg != MAX_COUNT) begin
            count_next = count_reg + 8'd1;
          end
        end else if (sk == cand_mask) begin
          state_next = HELD;
        end else begin
          count_next = 8'd0;
        end
      end
      default: begin
        count_next = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    valid_next   = (state_reg == DEB_PRESS) && (state_next == HELD);
    pressed_next = (state_next == HELD) || (state_next == DEB_RELEASE);
    bcd_next     = valid_next ? cand_reg : bcd_reg;
    multi_next   = (sk_ones > 4'd1);
  end

  assign numpad_pressed = pressed_reg;
  assign bcd            = bcd_reg;
  assign key_valid      = valid_reg;
  assign multi_key      = multi_reg;

endmodule

// File: tb/tb_numpad_encoder.sv
// Directed bench for numpad_encoder with DEBOUNCE_CYCLES=4.
module tb_numpad_encoder;

  logic       clk;
  logic       rst_n;
  logic [9:0] keypad;
  logic       numpad_pressed;
  logic [3:0] bcd;
  logic       key_valid;
  logic       multi_key;

  int vec;
  int errs;

  numpad_encoder #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .keypad        (keypad),
    .numpad_pressed(numpad_pressed),
    .bcd           (bcd),
    .key_valid     (key_valid),
    .multi_key     (multi_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 2 time units before sampling or driving.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    keypad = 10'd0;
    repeat (10) step();
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    keypad = 10'd0;
    repeat (3) step();
    vec++;
    if ({numpad_pressed, bcd, key_valid, multi_key} !== 7'd0) begin
      errs++;
      $display("FAIL reset_outputs got %b exp 0000000", {numpad_pressed, bcd, key_valid, multi_key});
    end
    rst_n = 1'b1;
    repeat (3) step();
    vec++;
    if ({numpad_pressed, key_valid} !== 2'b00) begin
      errs++;
      $display("FAIL reset_idle got %b exp 00", {numpad_pressed, key_valid});
    end
  endtask

  // Key 5 held from edge 1: pressed and strobe after edge 6, then clean release.
  task automatic test_basic_press();
    keypad = 10'b00_0010_0000;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (key_valid !== (e == 6) || numpad_pressed !== (e == 6)) begin
        errs++;
        $display("FAIL basic_press e=%0d got valid=%b pressed=%b exp %b", e, key_valid, numpad_pressed, (e == 6));
      end
    end
    vec++;
    if (bcd !== 4'd5) begin
      errs++;
      $display("FAIL basic_bcd got %0d exp 5", bcd);
    end
    step();
    vec++;
    if (key_valid !== 1'b0 || numpad_pressed !== 1'b1) begin
      errs++;
      $display("FAIL basic_strobe_width got valid=%b pressed=%b exp 0 1", key_valid, numpad_pressed);
    end
    keypad = 10'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (numpad_pressed !== (e < 6)) begin
        errs++;
        $display("FAIL basic_release e=%0d got %b exp %b", e, numpad_pressed, (e < 6));
      end
    end
    settle();
  endtask

  // Key 7 bounces 1,0,1 then stays: the restart pushes acceptance to edge 8.
  task automatic test_bounce();
    int pulses;
    pulses = 0;
    for (int e = 1; e <= 14; e++) begin
      keypad = (e == 2) ? 10'd0 : 10'b00_1000_0000;
      step();
      if (key_valid) pulses++;
      vec++;
      if (numpad_pressed !== (e >= 8)) begin
        errs++;
        $display("FAIL bounce_pressed e=%0d got %b exp %b", e, numpad_pressed, (e >= 8));
      end
    end
    vec++;
    if (pulses != 1 || bcd !== 4'd7) begin
      errs++;
      $display("FAIL bounce_result got pulses=%0d bcd=%0d exp 1 7", pulses, bcd);
    end
    settle();
  endtask

  // Key 3 held, 2-cycle release glitch, then clean release.
  task automatic test_release_glitch();
    int pulses;
    pulses = 0;
    keypad = 10'b00_0000_1000;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (key_valid) pulses++;
    end
    for (int e = 1; e <= 12; e++) begin
      keypad = (e <= 2) ? 10'd0 : 10'b00_0000_1000;
      step();
      if (key_valid) pulses++;
      vec++;
      if (numpad_pressed !== 1'b1) begin
        errs++;
        $display("FAIL glitch_hold e=%0d got %b exp 1", e, numpad_pressed);
      end
    end
    keypad = 10'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (key_valid) pulses++;
      vec++;
      if (numpad_pressed !== (e < 6)) begin
        errs++;
        $display("FAIL glitch_release e=%0d got %b exp %b", e, numpad_pressed, (e < 6));
      end
    end
    vec++;
    if (pulses != 1 || bcd !== 4'd3) begin
      errs++;
      $display("FAIL glitch_result got pulses=%0d bcd=%0d exp 1 3", pulses, bcd);
    end
    settle();
  endtask

  // Keys 2 and 8 together from IDLE: flagged, never accepted.
  task automatic test_multi_key();
    int pulses;
    pulses = 0;
    keypad = 10'b01_0000_0100;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (key_valid) pulses++;
      vec++;
      if (multi_key !== (e >= 3) || numpad_pressed !== 1'b0) begin
        errs++;
        $display("FAIL multi_flag e=%0d got multi=%b pressed=%b exp %b 0", e, multi_key, numpad_pressed, (e >= 3));
      end
    end
    vec++;
    if (pulses != 0 || bcd !== 4'd3) begin
      errs++;
      $display("FAIL multi_result got pulses=%0d bcd=%0d exp 0 3", pulses, bcd);
    end
    keypad = 10'd0;
    repeat (3) step();
    vec++;
    if (multi_key !== 1'b0) begin
      errs++;
      $display("FAIL multi_clear got %b exp 0", multi_key);
    end
    settle();
  endtask

  // Key 9 held, key 1 added, key 9 dropped: key 1 only counts after a re-press.
  task automatic test_key_switch();
    int pulses;
    keypad = 10'b10_0000_0000;
    repeat (8) step();
    vec++;
    if (bcd !== 4'd9 || numpad_pressed !== 1'b1) begin
      errs++;
      $display("FAIL switch_first got bcd=%0d pressed=%b exp 9 1", bcd, numpad_pressed);
    end
    pulses = 0;
    keypad = 10'b10_0000_0010;
    repeat (6) begin
      step();
      if (key_valid) pulses++;
    end
    keypad = 10'b00_0000_0010;
    repeat (15) begin
      step();
      if (key_valid) pulses++;
    end
    vec++;
    if (pulses != 0 || bcd !== 4'd9 || numpad_pressed !== 1'b1) begin
      errs++;
      $display("FAIL switch_blocked got pulses=%0d bcd=%0d pressed=%b exp 0 9 1", pulses, bcd, numpad_pressed);
    end
    keypad = 10'd0;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (numpad_pressed !== (e < 6)) begin
        errs++;
        $display("FAIL switch_release e=%0d got %b exp %b", e, numpad_pressed, (e < 6));
      end
    end
    step();
    keypad = 10'b00_0000_0010;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (key_valid !== (e == 6)) begin
        errs++;
        $display("FAIL switch_repress e=%0d got %b exp %b", e, key_valid, (e == 6));
      end
    end
    vec++;
    if (bcd !== 4'd1) begin
      errs++;
      $display("FAIL switch_bcd got %0d exp 1", bcd);
    end
    settle();
  endtask

  // Reset pulse while key 4 held: immediate clear, then one fresh acceptance.
  task automatic test_reset_mid_hold();
    keypad = 10'b00_0001_0000;
    repeat (8) step();
    vec++;
    if (numpad_pressed !== 1'b1 || bcd !== 4'd4) begin
      errs++;
      $display("FAIL rstmid_pre got pressed=%b bcd=%0d exp 1 4", numpad_pressed, bcd);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({numpad_pressed, bcd, key_valid, multi_key} !== 7'd0) begin
      errs++;
      $display("FAIL rstmid_async got %b exp 0000000", {numpad_pressed, bcd, key_valid, multi_key});
    end
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (key_valid !== (e == 6) || bcd !== ((e == 6) ? 4'd4 : 4'd0)) begin
        errs++;
        $display("FAIL rstmid_repress e=%0d got valid=%b bcd=%0d exp %b %0d", e, key_valid, bcd, (e == 6), (e == 6) ? 4 : 0);
      end
    end
    settle();
  endtask

  // Two keys accepted back to back with only the minimum release gap.
  task automatic test_back_to_back();
    keypad = 10'b00_0000_0001;
    repeat (6) step();
    vec++;
    if (key_valid !== 1'b1 || bcd !== 4'd0) begin
      errs++;
      $display("FAIL b2b_first got valid=%b bcd=%0d exp 1 0", key_valid, bcd);
    end
    keypad = 10'd0;
    repeat (6) step();
    keypad = 10'b00_0100_0000;
    for (int e = 1; e <= 6; e++) begin
      step();
      vec++;
      if (key_valid !== (e == 6) || numpad_pressed !== (e == 6)) begin
        errs++;
        $display("FAIL b2b_second e=%0d got valid=%b pressed=%b exp %b", e, key_valid, numpad_pressed, (e == 6));
      end
    end
    vec++;
    if (bcd !== 4'd6) begin
      errs++;
      $display("FAIL b2b_bcd got %0d exp 6", bcd);
    end
    settle();
  endtask

  initial begin
    vec    = 0;
    errs   = 0;
    rst_n  = 1'b0;
    keypad = 10'd0;
    test_reset();
    test_basic_press();
    test_bounce();
    test_release_glitch();
    test_multi_key();
    test_key_switch();
    test_reset_mid_hold();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
